// File: rtl/pipe_pkg.sv
// Shared types for the pipeline scheduler: FSM states, halt causes, the
// per-cycle action chosen by the scheduler and the stage strobe bundle.
package pipe_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_DMEM_WAIT,
        ST_FLUSH,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'b00,
        CAUSE_TRAP  = 2'b01,
        CAUSE_BREAK = 2'b10
    } cause_t;

    typedef enum logic [3:0] {
        ACT_BOOT,
        ACT_EXC,
        ACT_DSTALL,
        ACT_REDIR,
        ACT_LOAD_USE,
        ACT_IMEM,
        ACT_IDLE,
        ACT_FLUSH,
        ACT_HALT
    } act_t;

    // Instruction word the IF/ID register loads on flush: add x0,x0,x0
    localparam logic [31:0] NOP_INSN = 32'h00000033;

    typedef struct packed {
        logic pc_hold;
        logic if_id_hold;
        logic if_id_flush;
        logic id_ex_hold;
        logic id_ex_flush;
        logic ex_mem_hold;
        logic mem_wb_flush;
    } strobe_t;

    // A register is never told to hold and flush at once; flush wins.
    function automatic strobe_t resolve(input strobe_t s);
        strobe_t r;
        r             = s;
        r.if_id_hold  = s.if_id_hold & ~s.if_id_flush;
        r.id_ex_hold  = s.id_ex_hold & ~s.id_ex_flush;
        return r;
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_sched.sv
// Pipeline stall/flush scheduler: merges hazard, redirect, memory-wait and
// exception events into per-stage hold/flush strobes; owns halt state and perf counters.
module pipe_sched
    import pipe_pkg::*;
#(
    parameter int unsigned REDIRECT_PENALTY = 1,
    parameter int unsigned CNT_W            = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load_use,
    input  logic             i_redirect,
    input  logic             i_imem_stall,
    input  logic             i_dmem_stall,
    input  logic             i_wb_vld,
    input  logic             i_wb_trap,
    input  logic             i_wb_break,
    input  logic             i_resume,
    output logic             o_pc_hold,
    output logic             o_if_id_hold,
    output logic             o_if_id_flush,
    output logic             o_id_ex_hold,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_hold,
    output logic             o_mem_wb_flush,
    output logic             o_halted,
    output logic [1:0]       o_halt_cause,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(REDIRECT_PENALTY - 1);

    state_t     state_q, state_d;
    cause_t     cause_q, cause_d;
    logic       pend_q, pend_d;
    logic [2:0] fcnt_q, fcnt_d;
    act_t       act;
    strobe_t    strb;
    logic       exc;
    logic       stall_en;
    logic       flush_en;

    assign exc = i_wb_vld & (i_wb_trap | i_wb_break);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_BOOT;
            cause_q <= CAUSE_NONE;
            pend_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pend_q  <= pend_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Pick one action per cycle; the priority order differs by state.
    always_comb begin
        act = ACT_IDLE;
        unique case (state_q)
            ST_BOOT: act = ACT_BOOT;
            ST_RUN: begin
                if      (exc)          act = ACT_EXC;
                else if (i_dmem_stall) act = ACT_DSTALL;
                else if (i_redirect)   act = ACT_REDIR;
                else if (i_load_use)   act = ACT_LOAD_USE;
                else if (i_imem_stall) act = ACT_IMEM;
                else                   act = ACT_IDLE;
            end
            ST_DMEM_WAIT: begin
                // A redirect seen during the wait is replayed on the first free cycle
                if      (i_dmem_stall) act = ACT_DSTALL;
                else if (pend_q)       act = ACT_REDIR;
                else if (exc)          act = ACT_EXC;
                else if (i_load_use)   act = ACT_LOAD_USE;
                else if (i_imem_stall) act = ACT_IMEM;
                else                   act = ACT_IDLE;
            end
            ST_FLUSH: begin
                if      (i_dmem_stall) act = ACT_DSTALL;
                else if (i_redirect)   act = ACT_REDIR;
                else                   act = ACT_FLUSH;
            end
            ST_HALT: act = ACT_HALT;
            default: act = ACT_BOOT;
        endcase
    end

    always_comb begin
        strb    = '0;
        state_d = state_q;
        cause_d = cause_q;
        pend_d  = pend_q;
        fcnt_d  = fcnt_q;
        unique case (act)
            ACT_BOOT: begin
                strb.pc_hold     = 1'b1;
                strb.if_id_flush = 1'b1;
                strb.id_ex_flush = 1'b1;
                state_d          = ST_RUN;
            end
            ACT_EXC: begin
                strb.pc_hold      = 1'b1;
                strb.if_id_flush  = 1'b1;
                strb.id_ex_flush  = 1'b1;
                strb.ex_mem_hold  = 1'b1;
                strb.mem_wb_flush = 1'b1;
                cause_d           = i_wb_trap ? CAUSE_TRAP : CAUSE_BREAK;
                pend_d            = 1'b0;
                state_d           = ST_HALT;
            end
            ACT_DSTALL: begin
                strb.pc_hold      = 1'b1;
                strb.if_id_hold   = 1'b1;
                strb.id_ex_hold   = 1'b1;
                strb.ex_mem_hold  = 1'b1;
                strb.mem_wb_flush = 1'b1;
                pend_d            = (state_q == ST_DMEM_WAIT) ? (pend_q | i_redirect) : i_redirect;
                state_d           = ST_DMEM_WAIT;
            end
            ACT_REDIR: begin
                strb.if_id_flush = 1'b1;
                strb.id_ex_flush = 1'b1;
                pend_d           = 1'b0;
                if (REDIRECT_PENALTY > 1) begin
                    fcnt_d  = FLUSH_RELOAD;
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ACT_LOAD_USE: begin
                strb.pc_hold     = 1'b1;
                strb.if_id_hold  = 1'b1;
                strb.id_ex_flush = 1'b1;
                state_d          = ST_RUN;
            end
            ACT_IMEM: begin
                strb.pc_hold     = 1'b1;
                strb.if_id_flush = 1'b1;
                state_d          = ST_RUN;
            end
            ACT_FLUSH: begin
                strb.if_id_flush = 1'b1;
                strb.pc_hold     = i_imem_stall;
                if (fcnt_q <= 3'd1) begin
                    fcnt_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    fcnt_d  = fcnt_q - 3'd1;
                end
            end
            ACT_HALT: begin
                strb.pc_hold      = 1'b1;
                strb.if_id_hold   = 1'b1;
                strb.id_ex_hold   = 1'b1;
                strb.ex_mem_hold  = 1'b1;
                strb.mem_wb_flush = 1'b1;
                if (i_resume) begin
                    cause_d = CAUSE_NONE;
                    state_d = ST_BOOT;
                end
            end
            default: state_d = ST_RUN;
        endcase
        strb = resolve(strb);
    end

    assign o_pc_hold      = strb.pc_hold;
    assign o_if_id_hold   = strb.if_id_hold;
    assign o_if_id_flush  = strb.if_id_flush;
    assign o_id_ex_hold   = strb.id_ex_hold;
    assign o_id_ex_flush  = strb.id_ex_flush;
    assign o_ex_mem_hold  = strb.ex_mem_hold;
    assign o_mem_wb_flush = strb.mem_wb_flush;
    assign o_halted       = (state_q == ST_HALT);
    assign o_halt_cause   = cause_q;

    assign stall_en = strb.pc_hold & (state_q != ST_HALT) & (state_q != ST_BOOT);
    assign flush_en = strb.if_id_flush & (state_q != ST_BOOT);

    sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (stall_en),
        .cnt   (o_stall_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (flush_en),
        .cnt   (o_flush_cnt)
    );

endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched with REDIRECT_PENALTY=2 and 4-bit counters.
module tb_pipe_sched;

    localparam int unsigned PEN = 2;
    localparam int unsigned CW  = 4;

    // Strobe order: pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_flush
    localparam logic [6:0] S_BOOT  = 7'b1010100;
    localparam logic [6:0] S_NONE  = 7'b0000000;
    localparam logic [6:0] S_LU    = 7'b1100100;
    localparam logic [6:0] S_REDIR = 7'b0010100;
    localparam logic [6:0] S_FLUSH = 7'b0010000;
    localparam logic [6:0] S_IMEM  = 7'b1010000;
    localparam logic [6:0] S_STALL = 7'b1101011;
    localparam logic [6:0] S_EXC   = 7'b1010111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_use, redirect, imem_stall, dmem_stall;
    logic          wb_vld, wb_trap, wb_break, resume;
    logic          pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
    logic          ex_mem_hold, mem_wb_flush, halted;
    logic [1:0]    halt_cause;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [6:0]    strb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_sched #(.REDIRECT_PENALTY(PEN), .CNT_W(CW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_load_use     (load_use),
        .i_redirect     (redirect),
        .i_imem_stall   (imem_stall),
        .i_dmem_stall   (dmem_stall),
        .i_wb_vld       (wb_vld),
        .i_wb_trap      (wb_trap),
        .i_wb_break     (wb_break),
        .i_resume       (resume),
        .o_pc_hold      (pc_hold),
        .o_if_id_hold   (if_id_hold),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_hold   (id_ex_hold),
        .o_id_ex_flush  (id_ex_flush),
        .o_ex_mem_hold  (ex_mem_hold),
        .o_mem_wb_flush (mem_wb_flush),
        .o_halted       (halted),
        .o_halt_cause   (halt_cause),
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt)
    );

    assign strb = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_flush};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        load_use   = 1'b0;
        redirect   = 1'b0;
        imem_stall = 1'b0;
        dmem_stall = 1'b0;
        wb_vld     = 1'b0;
        wb_trap    = 1'b0;
        wb_break   = 1'b0;
        resume     = 1'b0;
    endtask

    // Leaves the DUT in RUN, one cycle after the BOOT cycle.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        settle();
        step();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        settle();
        check("rst_strb", 32'(strb), 32'(S_BOOT));
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        check("rst_flush_cnt", 32'(flush_cnt), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_cause", 32'(halt_cause), 0);
        step();
        step();
        rst_n = 1'b1;
        settle();
        check("boot_strb", 32'(strb), 32'(S_BOOT));
        step();
        settle();
        check("run_idle", 32'(strb), 32'(S_NONE));
        check("run_stall_cnt", 32'(stall_cnt), 0);
        check("run_flush_cnt", 32'(flush_cnt), 0);

        load_use = 1'b1;
        settle();
        check("lu_strb", 32'(strb), 32'(S_LU));
        step();
        load_use = 1'b0;
        settle();
        check("lu_after", 32'(strb), 32'(S_NONE));
        check("lu_stall_cnt", 32'(stall_cnt), 1);
        check("lu_flush_cnt", 32'(flush_cnt), 0);

        imem_stall = 1'b1;
        settle();
        check("imem_strb", 32'(strb), 32'(S_IMEM));
        step();
        imem_stall = 1'b0;
        settle();
        check("imem_stall_cnt", 32'(stall_cnt), 2);
        check("imem_flush_cnt", 32'(flush_cnt), 1);

        // Redirect with penalty 2; fetch stalls during the second flush cycle.
        do_reset();
        check("rd_cnt_clr", 32'(flush_cnt), 0);
        redirect = 1'b1;
        settle();
        check("rd_c0", 32'(strb), 32'(S_REDIR));
        step();
        redirect   = 1'b0;
        imem_stall = 1'b1;
        settle();
        check("rd_c1", 32'(strb), 32'(S_IMEM));
        step();
        imem_stall = 1'b0;
        settle();
        check("rd_c2", 32'(strb), 32'(S_NONE));
        check("rd_flush_cnt", 32'(flush_cnt), 2);
        check("rd_stall_cnt", 32'(stall_cnt), 1);

        // Three-cycle dmem stall with a redirect in its first cycle.
        do_reset();
        dmem_stall = 1'b1;
        redirect   = 1'b1;
        load_use   = 1'b1;
        settle();
        check("dm_c1", 32'(strb), 32'(S_STALL));
        step();
        redirect = 1'b0;
        settle();
        check("dm_c2", 32'(strb), 32'(S_STALL));
        step();
        settle();
        check("dm_c3", 32'(strb), 32'(S_STALL));
        step();
        dmem_stall = 1'b0;
        settle();
        check("dm_c4", 32'(strb), 32'(S_REDIR));
        step();
        load_use = 1'b0;
        settle();
        check("dm_c5", 32'(strb), 32'(S_FLUSH));
        step();
        settle();
        check("dm_c6", 32'(strb), 32'(S_NONE));
        check("dm_stall_cnt", 32'(stall_cnt), 3);
        check("dm_flush_cnt", 32'(flush_cnt), 2);

        // Trap and break retire together: trap is the recorded cause.
        do_reset();
        wb_vld   = 1'b1;
        wb_trap  = 1'b1;
        wb_break = 1'b1;
        settle();
        check("exc_strb", 32'(strb), 32'(S_EXC));
        step();
        clear_inputs();
        settle();
        check("halt_flag", 32'(halted), 1);
        check("halt_cause", 32'(halt_cause), 1);
        check("halt_stall_cnt0", 32'(stall_cnt), 1);
        check("halt_flush_cnt0", 32'(flush_cnt), 1);
        for (int i = 0; i < 100; i++) begin
            load_use   = 1'($urandom);
            redirect   = 1'($urandom);
            imem_stall = 1'($urandom);
            dmem_stall = 1'($urandom);
            wb_vld     = 1'($urandom);
            wb_trap    = 1'($urandom);
            wb_break   = 1'($urandom);
            settle();
            check("halt_hold", 32'(strb), 32'(S_STALL));
            step();
        end
        clear_inputs();
        settle();
        check("halt_still", 32'(halted), 1);
        check("halt_stall_frz", 32'(stall_cnt), 1);
        check("halt_flush_frz", 32'(flush_cnt), 1);
        resume = 1'b1;
        settle();
        check("resume_strb", 32'(strb), 32'(S_STALL));
        step();
        resume = 1'b0;
        settle();
        check("resume_boot", 32'(strb), 32'(S_BOOT));
        check("resume_cause", 32'(halt_cause), 0);
        check("resume_halted", 32'(halted), 0);
        step();
        settle();
        check("resume_run", 32'(strb), 32'(S_NONE));
        check("resume_stall_cnt", 32'(stall_cnt), 1);

        // Saturation of the 4-bit stall counter.
        do_reset();
        load_use = 1'b1;
        repeat (20) step();
        load_use = 1'b0;
        settle();
        check("sat_stall_cnt", 32'(stall_cnt), 15);
        check("sat_flush_cnt", 32'(flush_cnt), 0);

        // Asynchronous reset while in FLUSH.
        do_reset();
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        settle();
        check("ar_pre_strb", 32'(strb), 32'(S_FLUSH));
        check("ar_pre_flush_cnt", 32'(flush_cnt), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_strb", 32'(strb), 32'(S_BOOT));
        check("ar_flush_cnt", 32'(flush_cnt), 0);
        step();
        settle();
        check("ar_edge_strb", 32'(strb), 32'(S_BOOT));
        rst_n = 1'b1;
        settle();
        check("ar_boot_strb", 32'(strb), 32'(S_BOOT));
        step();
        settle();
        check("ar_run_strb", 32'(strb), 32'(S_NONE));
        check("ar_run_flush_cnt", 32'(flush_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
